r_channel_tx: RTL and testbench
===============================

R_CHANNEL_TX -- requirements
Module: r_channel_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of read data returned to the OBI manager.
REQ-002 SHALL have parameter ID_WIDTH, default 4, the width of the response ID (rid).
REQ-003 SHALL have parameter DEPTH, default 2, the number of response buffer entries; legal values are powers of two, 2 or more.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port resp_valid, input, 1 bit: the controller offers a response.
REQ-007 SHALL have port resp_rdata, input, DATA_WIDTH bits: response data (0 for write responses).
REQ-008 SHALL have port resp_rid, input, ID_WIDTH bits: ID of the originating A-channel request.
REQ-009 SHALL have port resp_err, input, 1 bit: error flag for the response.
REQ-010 SHALL have port resp_ready, output, 1 bit: the buffer can accept a response this cycle.
REQ-011 SHALL have port rvalid, output, 1 bit: OBI R-channel valid.
REQ-012 SHALL have port rready, input, 1 bit: OBI R-channel ready from the manager.
REQ-013 SHALL have port rdata, output, DATA_WIDTH bits: OBI read data.
REQ-014 SHALL have port rid, output, ID_WIDTH bits: OBI response ID.
REQ-015 SHALL have port err, output, 1 bit: OBI response error.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1 bits: current buffer occupancy.
REQ-017 SHALL have port drop_err, output, 1 bit: sticky flag, set when a response is offered while the buffer is full.

Function
REQ-018 SHALL implement a DEPTH-entry FIFO of {rdata, rid, err} with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-019 SHALL drive resp_ready = (count != DEPTH), derived only from registered state.
REQ-020 SHALL push the input entry and advance the write pointer on a clock edge where resp_valid && resp_ready.
REQ-021 SHALL drive rvalid = (count != 0), derived only from registered state; rvalid has no combinational path from resp_valid.
REQ-022 SHALL present the head entry on rdata/rid/err while rvalid is 1, and drive them to 0 while rvalid is 0.
REQ-023 SHALL pop the head and advance the read pointer on an edge where rvalid && rready.
REQ-024 SHALL keep rvalid, rdata, rid and err stable from the cycle rvalid rises until the cycle it is accepted by rready.
REQ-025 SHALL update count as: push only -> +1; pop only -> -1; push and pop in the same cycle -> unchanged, with both pointers advancing.
REQ-026 SHALL add latency of exactly 1 cycle: a response pushed at edge N into an empty buffer has rvalid=1 in the cycle after edge N.
REQ-027 SHALL, when full with rready=1, still deassert resp_ready that cycle; there is no same-cycle pass-through of a new entry.
REQ-028 SHALL, on resp_valid=1 while full, leave buffer, pointers and count unmodified and set drop_err to 1 at that edge.
REQ-029 SHALL deliver responses in push order, with no reordering by ID.
REQ-030 SHALL never let count exceed DEPTH or underflow below 0.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, clear both pointers, count and drop_err to 0, regardless of any concurrent push or pop.
REQ-032 SHALL give these output values after reset: rvalid=0, rdata=0, rid=0, err=0, resp_ready=1, count=0, drop_err=0.
REQ-033 SHALL discard all entries buffered when rst is asserted mid-operation; buffer storage contents need no reset.

Verification
REQ-034 SHALL cover single response: push {rdata=0xDEADBEEF, rid=3, err=0} with rready=1 -> rvalid=1 one cycle later with those values, then rvalid=0 and count=0.
REQ-035 SHALL cover backpressure: rready=0, push rid 1 then rid 2 (DEPTH=2) -> count=2, resp_ready=0, rid=1 held stable; then rready=1 -> rid 1 then rid 2 delivered on consecutive cycles.
REQ-036 SHALL cover overflow: buffer full, resp_valid=1 with rid=7 -> count stays 2, drop_err=1 and remains 1, rid 7 never appears on rid.
REQ-037 SHALL cover simultaneous events: count=1, push and pop in the same cycle -> count stays 1, next head is the newly pushed entry, and pointers wrap correctly after DEPTH+1 such cycles.
REQ-038 SHALL cover error propagation: push {err=1, rdata=0, rid=5} -> err=1, rid=5 while rvalid=1.
REQ-039 SHALL cover reset mid-operation: count=2 with drop_err=1, assert rst for one cycle -> all values per REQ-032, and no stale entry reappears on rvalid afterwards.

Source files
------------

// File: rtl/r_channel_tx.sv
// r_channel_tx: buffers controller responses in a small FIFO and drives them onto the OBI R channel
module r_channel_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       resp_valid,
  input  logic [DATA_WIDTH-1:0]      resp_rdata,
  input  logic [ID_WIDTH-1:0]        resp_rid,
  input  logic                       resp_err,
  output logic                       resp_ready,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic [ID_WIDTH-1:0]        rid,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + ID_WIDTH + 1;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic drop_q, drop_d, push, pop;
  // handshakes come from registered occupancy only, so rvalid never depends on resp_valid
  always_comb begin
    resp_ready = count_q != CW'(DEPTH);
    rvalid = count_q != '0;
    push = resp_valid && resp_ready;
    pop = rvalid && rready;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
    drop_d = drop_q || (resp_valid && !resp_ready);
    {rdata, rid, err} = rvalid ? mem_q[rd_ptr_q] : '0;
  end
  assign count = count_q;
  assign drop_err = drop_q;
  // storage holds no reset; stale slots are unreachable once pointers and count clear
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {resp_rdata, resp_rid, resp_err};
  end
  // pointer, occupancy and sticky drop flag state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      drop_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_r_channel_tx.sv
// tb_r_channel_tx: scoreboard bench for r_channel_tx
module tb_r_channel_tx;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int DEPTH = 2;
  logic clk = 0;
  logic rst = 1;
  logic resp_valid = 0;
  logic [DW-1:0] resp_rdata = '0;
  logic [IW-1:0] resp_rid = '0;
  logic resp_err = 0;
  logic resp_ready, rvalid, err, drop_err;
  logic rready = 0;
  logic [DW-1:0] rdata;
  logic [IW-1:0] rid;
  logic [$clog2(DEPTH):0] count;
  logic [DW+IW:0] exp_q[$];
  logic model_drop = 0;
  int checks = 0;
  int errors = 0;

  r_channel_tx #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_rid(resp_rid), .resp_err(resp_err), .resp_ready(resp_ready),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .err(err),
    .count(count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    logic do_push, do_pop;
    do_push = !rst && resp_valid && exp_q.size() < DEPTH;
    do_pop = !rst && rready && exp_q.size() != 0;
    if (do_pop) begin
      checks++;
      if ({rvalid, rdata, rid, err} !== {1'b1, exp_q[0]}) begin
        errors++;
        $display("FAIL sb_pop got v=%0b d=%h id=%0d e=%0b exp d=%h id=%0d e=%0b", rvalid, rdata, rid, err,
                 exp_q[0][DW+IW:IW+1], exp_q[0][IW:1], exp_q[0][0]);
      end
      void'(exp_q.pop_front());
    end
    if (do_push) exp_q.push_back({resp_rdata, resp_rid, resp_err});
    if (!rst && resp_valid && !do_push) model_drop = 1;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      model_drop = 0;
    end
    checks++;
    if (rvalid !== (exp_q.size() != 0) || count !== exp_q.size() || drop_err !== model_drop) begin
      errors++;
      $display("FAIL sb_state got v=%0b cnt=%0d drop=%0b exp v=%0b cnt=%0d drop=%0b", rvalid, count, drop_err,
               exp_q.size() != 0, exp_q.size(), model_drop);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [IW-1:0] i, input logic e);
    resp_valid = v;
    resp_rdata = d;
    resp_rid = i;
    resp_err = e;
  endtask

  task automatic test_reset;
    rst = 1;
    tick;
    tick;
    rst = 0;
    checks++;
    if ({rvalid, rdata, rid, err, resp_ready, count, drop_err} !== {1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset got v=%0b d=%h id=%0d e=%0b rdy=%0b cnt=%0d drop=%0b exp 0 0 0 0 1 0 0",
               rvalid, rdata, rid, err, resp_ready, count, drop_err);
    end
  endtask

  task automatic test_single;
    rready = 1;
    drive(1, 32'hDEADBEEF, 4'd3, 0);
    tick;
    drive(0, 0, 0, 0);
    checks++;
    if ({rvalid, rdata, rid, err} !== {1'b1, 32'hDEADBEEF, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL single got v=%0b d=%h id=%0d e=%0b exp 1 deadbeef 3 0", rvalid, rdata, rid, err);
    end
    tick;
    checks++;
    if ({rvalid, rdata, count} !== {1'b0, 32'h0, 2'd0}) begin
      errors++;
      $display("FAIL single_idle got v=%0b d=%h cnt=%0d exp 0 0 0", rvalid, rdata, count);
    end
  endtask

  task automatic test_backpressure;
    rready = 0;
    drive(1, 32'h11, 4'd1, 0);
    tick;
    drive(1, 32'h22, 4'd2, 0);
    tick;
    drive(0, 0, 0, 0);
    checks++;
    if ({count, resp_ready, rid} !== {2'd2, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL bp_full got cnt=%0d rdy=%0b id=%0d exp 2 0 1", count, resp_ready, rid);
    end
    tick;
    checks++;
    if ({rvalid, rdata, rid} !== {1'b1, 32'h11, 4'd1}) begin
      errors++;
      $display("FAIL bp_hold got v=%0b d=%h id=%0d exp 1 11 1", rvalid, rdata, rid);
    end
    rready = 1;
    tick;
    checks++;
    if ({rvalid, rid} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL bp_second got v=%0b id=%0d exp 1 2", rvalid, rid);
    end
    tick;
    rready = 0;
  endtask

  task automatic test_overflow;
    rready = 0;
    drive(1, 32'hA1, 4'd1, 0);
    tick;
    drive(1, 32'hA2, 4'd2, 0);
    tick;
    drive(1, 32'hBAD, 4'd7, 1);
    tick;
    drive(0, 0, 0, 0);
    checks++;
    if ({count, drop_err, rid} !== {2'd2, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL ovf got cnt=%0d drop=%0b id=%0d exp 2 1 1", count, drop_err, rid);
    end
    rready = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (rvalid && rid === 4'd7) begin
        errors++;
        $display("FAIL ovf_leak got id=%0d exp not 7", rid);
      end
    end
    checks++;
    if ({rvalid, drop_err} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_sticky got v=%0b drop=%0b exp 0 1", rvalid, drop_err);
    end
    rready = 0;
  endtask

  task automatic test_simultaneous;
    rready = 0;
    drive(1, 32'h100, 4'd0, 0);
    tick;
    rready = 1;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      drive(1, 32'h100 + i, 4'(i), 0);
      tick;
      checks++;
      if ({count, rdata, rid} !== {2'd1, 32'h100 + i, 4'(i)}) begin
        errors++;
        $display("FAIL simul[%0d] got cnt=%0d d=%h id=%0d exp 1 %h %0d", i, count, rdata, rid, 32'h100 + i, i);
      end
    end
    drive(0, 0, 0, 0);
    tick;
    rready = 0;
  endtask

  task automatic test_error;
    rready = 0;
    drive(1, 32'h0, 4'd5, 1);
    tick;
    drive(0, 0, 0, 0);
    checks++;
    if ({rvalid, err, rid, rdata} !== {1'b1, 1'b1, 4'd5, 32'h0}) begin
      errors++;
      $display("FAIL err_prop got v=%0b e=%0b id=%0d d=%h exp 1 1 5 0", rvalid, err, rid, rdata);
    end
    rready = 1;
    tick;
    rready = 0;
  endtask

  task automatic test_reset_mid;
    rready = 0;
    drive(1, 32'hC1, 4'd9, 0);
    tick;
    drive(1, 32'hC2, 4'd10, 0);
    tick;
    drive(1, 32'hC3, 4'd11, 0);
    tick;
    checks++;
    if ({count, drop_err} !== {2'd2, 1'b1}) begin
      errors++;
      $display("FAIL rmid_pre got cnt=%0d drop=%0b exp 2 1", count, drop_err);
    end
    rst = 1;
    rready = 1;
    tick;
    rst = 0;
    drive(0, 0, 0, 0);
    checks++;
    if ({rvalid, rdata, rid, err, resp_ready, count, drop_err} !== {1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL rmid_post got v=%0b d=%h id=%0d e=%0b rdy=%0b cnt=%0d drop=%0b exp 0 0 0 0 1 0 0",
               rvalid, rdata, rid, err, resp_ready, count, drop_err);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rmid_stale got v=%0b id=%0d exp v=0", rvalid, rid);
      end
    end
    rready = 0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_simultaneous;
    test_error;
    test_overflow;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
